sdp_ram_param: RTL
==================

SDP_RAM_PARAM -- requirements
Module: sdp_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which sets the data width and must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, which sets the depth: DEPTH = 2^ADDR_W words.
REQ-003 SHALL have parameter DO_REG, default 1, which adds an optional output register (0 or 1).
REQ-004 SHALL have parameter CLEAR_VAL, default 0 (DATA_W bits), which is the fill word written by the clear engine.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 0; when 1, a clear starts automatically on reset release.
REQ-006 clka  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 ena  in  1  read enable (port A).
REQ-009 addra  in  ADDR_W  read address.
REQ-010 douta  out  DATA_W  read data.
REQ-011 dvalida  out  1  one-cycle pulse marking douta valid.
REQ-012 enb  in  1  write enable (port B).
REQ-013 addrb  in  ADDR_W  write address.
REQ-014 dinb  in  DATA_W  write data.
REQ-015 web  in  DATA_W/8  byte write enables; bit i gates dinb[8i+7:8i].
REQ-016 clr_req  in  1  clear request (level-sampled each cycle).
REQ-017 clr_busy  out  1  high while the clear engine owns port B.

Function
REQ-018 Read latency SHALL be 1+DO_REG cycles from ena sampled high to dvalida high, with douta valid in that same cycle.
REQ-019 douta SHALL hold its last value while no new read completes; dvalida SHALL be low otherwise.
REQ-020 A write SHALL occur when enb=1 and clr_busy=0, updating only the bytes whose web bit is 1; web=0 with enb=1 is a no-op.
REQ-021 A read and a write to the same address in the same cycle SHALL be read-first: the read returns the pre-write word.
REQ-022 The clear FSM SHALL have two states, IDLE and CLEAR, plus a counter clr_addr of ADDR_W bits.
REQ-023 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with clr_addr=0.
REQ-024 In CLEAR, each cycle SHALL write CLEAR_VAL (all bytes) to clr_addr and increment clr_addr; after writing DEPTH-1 the FSM SHALL return to IDLE, for exactly DEPTH cycles in CLEAR.
REQ-025 clr_busy SHALL equal (state==CLEAR), with no extra cycle at either end.
REQ-026 In CLEAR, user writes on port B SHALL be dropped silently; clr_req SHALL be ignored; reads SHALL still be served and may return a mix of old data and CLEAR_VAL.
REQ-027 clr_req held high through the return to IDLE SHALL start a new clear on the next cycle.

Reset
REQ-028 rst SHALL force douta=0, dvalida=0, the pipeline valid bits to 0, state=IDLE (or CLEAR with clr_addr=0 when CLEAR_ON_RESET=1), and clr_addr=0.
REQ-029 Memory contents SHALL NOT be reset; a read in flight SHALL be discarded.
REQ-030 rst asserted mid-clear SHALL abort the clear, leaving a partially cleared array; with CLEAR_ON_RESET=1 the clear SHALL restart from address 0.

Structure
REQ-031 The shared package sdp_ram_pkg SHALL hold the FSM state encoding (IDLE=0, CLEAR=1) and the default DATA_W/ADDR_W constants.
REQ-032 The storage array SHALL be a sub-module, sdp_ram_core: a plain inferred read-first SDP array with byte-enable write and a 1-cycle registered read and no reset; the wrapper holds the DO_REG stage, the valid pipeline and the clear FSM.

Verification
REQ-033 Write 16'hA5A5 to address 5 with web=2'b11, then read address 5 -> douta=16'hA5A5 with dvalida high 2 cycles after ena (1 cycle when DO_REG=0).
REQ-034 Write 16'h1234 to address 7, then write 16'hFFFF with web=2'b01 -> a read of address 7 returns 16'h12FF.
REQ-035 Read and write address 9 in the same cycle (old 16'h0001, new 16'h0002) -> that read returns 16'h0001 and the next read returns 16'h0002.
REQ-036 Pulse clr_req with CLEAR_VAL=16'hBEEF and ADDR_W=4 -> clr_busy high for exactly 16 cycles, a user write during busy is dropped, and all 16 addresses read 16'hBEEF.
REQ-037 Assert rst at clr_addr=8 with CLEAR_ON_RESET=0 -> clr_busy=0, douta=0, addresses 0-7 cleared, 8-15 unchanged; with CLEAR_ON_RESET=1 -> clear restarts and completes after 16 cycles.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared constants and clear-engine state encoding for the SDP RAM
package sdp_ram_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;
endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: inferred read-first simple dual-port array, byte-enable write, registered read, no reset
module sdp_ram_core
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // read samples the pre-write word because both updates are non-blocking on the same edge
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < DATA_W/8; i++)
      if (we && wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/sdp_ram_param.sv
// sdp_ram_param: SDP RAM wrapper with optional output register, read-valid pipeline and clear engine
module sdp_ram_param
  import sdp_ram_pkg::*;
#(
  parameter int                DATA_W         = DEF_DATA_W,
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter int                DO_REG         = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter int                CLEAR_ON_RESET = 0
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                ena,
  input  logic [ADDR_W-1:0]   addra,
  output logic [DATA_W-1:0]   douta,
  output logic                dvalida,
  input  logic                enb,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  input  logic [DATA_W/8-1:0] web,
  input  logic                clr_req,
  output logic                clr_busy
);
  localparam clr_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  clr_state_t          state, state_nx;
  logic [ADDR_W-1:0]   clr_addr;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wbe;
  logic [DATA_W-1:0]   q;
  logic                v1;
  logic [DATA_W-1:0]   dr;
  sdp_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk  (clka),
    .re   (ena),
    .raddr(addra),
    .rdata(q),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .wbe  (wbe)
  );
  // clear engine state and sweep address; the address parks at 0 whenever idle
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= (state == CLEAR) ? clr_addr + ADDR_W'(1) : '0;
    end
  end
  // leave CLEAR right after the last address is written
  always_comb begin
    state_nx = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : (&clr_addr ? IDLE : CLEAR);
  end
  // the clear engine takes port B outright, dropping user writes while busy
  always_comb begin
    clr_busy = (state == CLEAR);
    we       = clr_busy | (enb & |web);
    waddr    = clr_busy ? clr_addr : addrb;
    wdata    = clr_busy ? CLEAR_VAL : dinb;
    wbe      = clr_busy ? '1 : web;
  end
  // first valid stage tracks the core read; dr keeps the last completed word so douta can hold and reset to 0
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      dr <= '0;
    end else begin
      v1 <= ena;
      if (v1) dr <= q;
    end
  end
  if (DO_REG != 0) begin : g_reg
    logic v2;
    // second valid stage aligned with the output register
    always_ff @(posedge clka or posedge rst) begin
      if (rst) v2 <= 1'b0;
      else v2 <= v1;
    end
    assign douta   = dr;
    assign dvalida = v2;
  end else begin : g_comb
    assign douta   = v1 ? q : dr;
    assign dvalida = v1;
  end
endmodule
